// File: rtl/m216a_pe_stream.sv
`default_nettype none
// ============================================================================
// m216a_pe_stream : valid-qualified multi-function PE, configurable latency
// Rev 1.0
// ============================================================================
module m216a_pe_stream #(
  parameter int DATA_W    = 16,
  parameter int LAT       = 2,
  parameter int DLY_EXTRA = 2
) (
  input  logic              Clk_In,
  input  logic              Rst_In,
  input  logic              In_Valid,
  input  logic [15:0]       Instruction_In,
  input  logic [DATA_W-1:0] D_In1,
  input  logic [DATA_W-1:0] D_In2,
  input  logic [DATA_W-1:0] D_In3,
  output logic [DATA_W-1:0] D_Out,
  output logic              Out_Valid,
  output logic              Err_Out
);

  localparam int c_DLAT = LAT + DLY_EXTRA;
  localparam int c_QD   = DLY_EXTRA + 1;
  localparam int c_TN   = c_QD + 2;
  localparam int c_QCW  = $clog2(c_QD + 1);
  localparam int c_EW   = DATA_W + 1;

  localparam logic [3:0] c_OP_PASS = 4'd1;
  localparam logic [3:0] c_OP_PDLY = 4'd2;
  localparam logic [3:0] c_OP_ADD  = 4'd3;
  localparam logic [3:0] c_OP_MUL  = 4'd4;
  localparam logic [3:0] c_OP_MAC3 = 4'd5;
  localparam logic [3:0] c_OP_ACC7 = 4'd6;
  localparam logic [3:0] c_OP_STEN = 4'd7;
  localparam logic [3:0] c_OP_DOT  = 4'd8;
  localparam logic [3:0] c_OP_SAT  = 4'd9;
  localparam logic [DATA_W-1:0] c_SEVEN = DATA_W'(7);

  logic [3:0]        r_cur_op;
  logic [DATA_W-1:0] r_x1, r_x2, r_acc;
  logic [1:0]        r_smp_cnt;
  logic [LAT:1]      r_mv;
  logic [c_EW-1:0]   r_me [1:LAT];
  logic [c_DLAT:1]   r_dv;
  logic [c_EW-1:0]   r_de [1:c_DLAT];
  logic [c_EW-1:0]   r_q  [0:c_QD-1];
  logic [c_QCW-1:0]  r_q_cnt;

  logic [3:0]        w_op;
  logic              w_sw, w_err, w_emit, w_push_m, w_push_d;
  logic [DATA_W-1:0] w_x1, w_x2, w_acc, w_acc_nx, w_res;
  logic [1:0]        w_cnt, w_cnt_nx;
  logic [DATA_W:0]   w_sum;
  logic              w_unused_instr;

  assign w_op           = Instruction_In[3:0];
  assign w_unused_instr = ^Instruction_In[15:4];
  assign w_sum          = {1'b0, D_In2} + {1'b0, D_In3};

  // A mode switch presents cleared history to the sample that causes it.
  always_comb begin
    w_sw     = (w_op != r_cur_op);
    w_x1     = w_sw ? '0 : r_x1;
    w_x2     = w_sw ? '0 : r_x2;
    w_acc    = w_sw ? '0 : r_acc;
    w_cnt    = w_sw ? '0 : r_smp_cnt;
    w_cnt_nx = (w_cnt == 2'd3) ? 2'd3 : w_cnt + 2'd1;
    w_res    = '0;
    w_err    = 1'b0;
    w_emit   = 1'b1;
    w_acc_nx = w_acc;
    case (w_op)
      c_OP_PASS, c_OP_PDLY: w_res = D_In1;
      c_OP_ADD:  w_res = D_In2 + D_In3;
      c_OP_MUL:  w_res = D_In1 * D_In2;
      c_OP_MAC3: w_res = D_In1 + DATA_W'(D_In2 * D_In3);
      c_OP_ACC7: begin
        w_acc_nx = w_acc + DATA_W'(D_In3 * c_SEVEN);
        w_res    = w_acc_nx;
      end
      c_OP_STEN: begin
        w_res  = DATA_W'(w_x2 * w_x1) + D_In1;
        w_emit = (w_cnt_nx == 2'd3);
      end
      c_OP_DOT: begin
        w_acc_nx = w_acc + DATA_W'(w_x1 * D_In1);
        w_res    = w_acc_nx;
        w_emit   = (w_cnt_nx >= 2'd2);
      end
      c_OP_SAT:  w_res = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
      default:   w_err = 1'b1;
    endcase
    w_push_d = In_Valid && w_emit && (w_op == c_OP_PDLY);
    w_push_m = In_Valid && w_emit && (w_op != c_OP_PDLY);
  end

  // Completion merge: the delay pipe always holds the older result, so it
  // goes ahead of the main pipe; anything not emitted waits in r_q.
  logic [c_EW-1:0]  w_tmp  [0:c_TN-1];
  logic [c_EW-1:0]  w_q_nx [0:c_QD-1];
  logic [c_QCW-1:0] w_q_cnt_nx;
  logic [c_EW-1:0]  w_out;
  logic             w_out_v;
  int               w_n;

  always_comb begin
    for (int i = 0; i < c_TN; i++) w_tmp[i] = '0;
    for (int i = 0; i < c_QD; i++) w_tmp[i] = r_q[i];
    w_n = int'(r_q_cnt);
    if (r_dv[c_DLAT]) begin
      for (int i = 0; i < c_TN; i++) if (i == w_n) w_tmp[i] = r_de[c_DLAT];
      w_n = w_n + 1;
    end
    if (r_mv[LAT]) begin
      for (int i = 0; i < c_TN; i++) if (i == w_n) w_tmp[i] = r_me[LAT];
      w_n = w_n + 1;
    end
    w_out_v = (w_n > 0);
    w_out   = w_tmp[0];
    for (int i = 0; i < c_QD; i++) w_q_nx[i] = w_tmp[i+1];
    w_q_cnt_nx = (w_n > 0) ? c_QCW'(w_n - 1) : '0;
  end

  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      r_cur_op  <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_acc     <= '0;
      r_smp_cnt <= '0;
      r_mv      <= '0;
      r_dv      <= '0;
      r_q_cnt   <= '0;
      D_Out     <= '0;
      Out_Valid <= 1'b0;
      Err_Out   <= 1'b0;
    end else begin
      if (In_Valid) begin
        r_cur_op  <= w_op;
        r_x1      <= D_In1;
        r_x2      <= w_x1;
        r_acc     <= w_acc_nx;
        r_smp_cnt <= w_cnt_nx;
      end
      r_mv[1] <= w_push_m;
      r_me[1] <= {w_err, w_res};
      for (int i = 2; i <= LAT; i++) begin
        r_mv[i] <= r_mv[i-1];
        r_me[i] <= r_me[i-1];
      end
      r_dv[1] <= w_push_d;
      r_de[1] <= {w_err, w_res};
      for (int i = 2; i <= c_DLAT; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_de[i] <= r_de[i-1];
      end
      for (int i = 0; i < c_QD; i++) r_q[i] <= w_q_nx[i];
      r_q_cnt   <= w_q_cnt_nx;
      Out_Valid <= w_out_v;
      if (w_out_v) {Err_Out, D_Out} <= w_out;
    end
  end

endmodule
`default_nettype wire
